// File: rtl/mdio_pkg.sv
// Shared types and constants for the clause-22 MDIO responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_SKIP
    } mdio_state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_STATUS   = 5'd1;
    localparam logic [4:0] REG_ID1      = 5'd2;
    localparam logic [4:0] REG_ID2      = 5'd3;
    localparam logic [4:0] REG_GBIT     = 5'd9;
    localparam logic [4:0] REG_EXT_ADDR = 5'd11;
    localparam logic [4:0] REG_EXT_DATA = 5'd12;
    localparam logic [4:0] REG_PHY_SPEC = 5'd31;

    localparam logic [15:0] CTRL_RST   = 16'h1140;
    localparam logic [15:0] GBIT_RST   = 16'h0300;
    localparam logic [15:0] STATUS_VAL = 16'h796D;
    localparam logic [15:0] EXT_RST    = 16'h0000;

    localparam logic [8:0] EXT_CLK_SKEW = 9'h104;
    localparam logic [8:0] EXT_RX_SKEW  = 9'h105;
    localparam logic [8:0] EXT_TX_SKEW  = 9'h106;

    // Bit-counter load value on entering a state: field length minus one.
    function automatic logic [4:0] field_last(input mdio_state_t s);
        case (s)
            S_OP:    return 5'd1;
            S_PHYAD: return 5'd4;
            S_REGAD: return 5'd4;
            S_TA:    return 5'd1;
            S_DATA:  return 5'd15;
            S_SKIP:  return 5'd17;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Two-flop synchronizers for MDC/MDIO plus MDC rising-edge detect in the clock domain.
module mdio_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);

    logic [2:0] mdc_q;
    logic [1:0] mdio_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mdc_q  <= 3'b000;
            mdio_q <= 2'b11;
        end else begin
            mdc_q  <= {mdc_q[1:0], mdc};
            mdio_q <= {mdio_q[0], mdio_i};
        end
    end

    // mdio_q[1] has the same latency as mdc_q[1], so data is aligned with the edge.
    assign mdc_rise = mdc_q[1] & ~mdc_q[2];
    assign mdio_s   = mdio_q[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side target with a small register set; MDIO_EXT_REG_EN adds reg 11/12 extended access.
//  state | meaning
//  IDLE  | counting preamble ones     ST    | expect start bit 1
//  OP    | 2 opcode bits              PHYAD | 5 address bits
//  REGAD | 5 register bits            TA    | turnaround
//  DATA  | 16 data bits               SKIP  | frame for another PHY
module mdio_responder
    import mdio_pkg::*;
#(
    parameter int          PREAMBLE_BITS = 32,
    parameter logic [15:0] ID1           = 16'h0022,
    parameter logic [15:0] ID2           = 16'h1611
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  phy_addr,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [1:0]  link_speed,
    input  logic        link_duplex,
    output logic [15:0] ctrl_reg,
    output logic [15:0] gbit_ctrl,
    output logic        soft_reset,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
`ifdef MDIO_EXT_REG_EN
    output logic [15:0] clk_skew,
    output logic [15:0] rx_skew,
    output logic [15:0] tx_skew,
`endif
    output logic [15:0] wr_data
);

    localparam int OW = $clog2(PREAMBLE_BITS + 1);

    mdio_state_t state, state_nxt;
    logic          mdc_rise, mdio_s;
    logic [OW-1:0] ones_cnt;
    logic [4:0]    bit_cnt;
    logic [14:0]   shift;
    logic [15:0]   shift_nxt, rd_value, rd_shift;
    logic [4:0]    reg_addr;
    logic          is_read, last_bit;
    logic [15:0]   regs [4:15];

    mdio_edge_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_s)
    );

    assign gbit_ctrl = regs[REG_GBIT[3:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = {shift, mdio_s};
        last_bit  = (bit_cnt == 5'd0);
        if (mdc_rise) begin
            case (state)
                S_IDLE:  if (!mdio_s && ones_cnt >= OW'(PREAMBLE_BITS)) state_nxt = S_ST;
                S_ST:    state_nxt = mdio_s ? S_OP : S_IDLE;
                S_OP:    if (last_bit)
                             state_nxt = (shift_nxt[1:0] == OP_READ || shift_nxt[1:0] == OP_WRITE)
                                         ? S_PHYAD : S_IDLE;
                S_PHYAD: if (last_bit) state_nxt = S_REGAD;
                S_REGAD: if (last_bit) state_nxt = (shift_nxt[9:5] == phy_addr) ? S_TA : S_SKIP;
                S_TA:    if (last_bit) state_nxt = S_DATA;
                S_DATA:  if (last_bit) state_nxt = S_IDLE;
                S_SKIP:  if (last_bit) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef MDIO_EXT_REG_EN
    logic [15:0] ext_value;
    always_comb begin
        ext_value = '0;
        case (regs[REG_EXT_ADDR[3:0]][8:0])
            EXT_CLK_SKEW: ext_value = clk_skew;
            EXT_RX_SKEW:  ext_value = rx_skew;
            EXT_TX_SKEW:  ext_value = tx_skew;
            default:      ext_value = '0;
        endcase
    end
`endif

    // Evaluated at REGAD completion, where shift_nxt[4:0] is the register address.
    always_comb begin
        rd_value = '0;
        case (shift_nxt[4:0])
            REG_CTRL:     rd_value = ctrl_reg;
            REG_STATUS:   rd_value = STATUS_VAL;
            REG_ID1:      rd_value = ID1;
            REG_ID2:      rd_value = ID2;
            REG_PHY_SPEC: rd_value = {9'b0, link_speed, 1'b0, link_duplex, 3'b0};
`ifdef MDIO_EXT_REG_EN
            REG_EXT_DATA: rd_value = regs[REG_EXT_ADDR[3:0]][15] ? regs[REG_EXT_DATA[3:0]] : ext_value;
`endif
            default: if (shift_nxt[4:0] >= 5'd4 && shift_nxt[4:0] <= 5'd15)
                         rd_value = regs[shift_nxt[3:0]];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rd_shift   <= '0;
            reg_addr   <= '0;
            is_read    <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_oe    <= 1'b0;
            ctrl_reg   <= CTRL_RST;
            soft_reset <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            for (int i = 4; i <= 15; i++) regs[i] <= (i == 9) ? GBIT_RST : 16'h0000;
`ifdef MDIO_EXT_REG_EN
            clk_skew   <= EXT_RST;
            rx_skew    <= EXT_RST;
            tx_skew    <= EXT_RST;
`endif
        end else begin
            wr_strobe  <= 1'b0;
            soft_reset <= 1'b0;
            if (mdc_rise) begin
                shift   <= shift_nxt[14:0];
                bit_cnt <= (state_nxt != state) ? field_last(state_nxt) : bit_cnt - 5'd1;
                if (state == S_IDLE && mdio_s)
                    ones_cnt <= (ones_cnt == OW'(PREAMBLE_BITS)) ? ones_cnt : ones_cnt + 1'b1;
                else
                    ones_cnt <= '0;
                case (state)
                    S_OP: if (last_bit) is_read <= (shift_nxt[1:0] == OP_READ);
                    S_REGAD: if (last_bit) begin
                        reg_addr <= shift_nxt[4:0];
                        rd_shift <= rd_value;
                    end
                    S_TA: if (is_read) begin
                        mdio_oe <= 1'b1;
                        if (!last_bit) begin
                            mdio_o <= 1'b0;
                        end else begin
                            mdio_o   <= rd_shift[15];
                            rd_shift <= {rd_shift[14:0], 1'b0};
                        end
                    end
                    S_DATA: if (is_read) begin
                        if (!last_bit) begin
                            mdio_o   <= rd_shift[15];
                            rd_shift <= {rd_shift[14:0], 1'b0};
                        end else begin
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b1;
                        end
                    end else if (last_bit) begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= reg_addr;
                        wr_data   <= shift_nxt;
                        if (reg_addr == REG_CTRL) begin
                            if (shift_nxt[15]) begin
                                ctrl_reg   <= CTRL_RST;
                                soft_reset <= 1'b1;
                            end else begin
                                ctrl_reg <= {1'b0, shift_nxt[14:0]};
                            end
`ifdef MDIO_EXT_REG_EN
                        end else if (reg_addr == REG_EXT_DATA && regs[REG_EXT_ADDR[3:0]][15]) begin
                            case (regs[REG_EXT_ADDR[3:0]][8:0])
                                EXT_CLK_SKEW: clk_skew <= shift_nxt;
                                EXT_RX_SKEW:  rx_skew  <= shift_nxt;
                                EXT_TX_SKEW:  tx_skew  <= shift_nxt;
                                default:      ;
                            endcase
`endif
                        end else if (reg_addr >= 5'd4 && reg_addr <= 5'd15) begin
                            regs[reg_addr[3:0]] <= shift_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed plus randomized bench for mdio_responder against a register-map reference model.
module tb_mdio_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  phy_addr;
    logic        mdc;
    logic        mdio_pin;
    logic        mdio_o, mdio_oe;
    logic [1:0]  link_speed;
    logic        link_duplex;
    logic [15:0] ctrl_reg, gbit_ctrl;
    logic        soft_reset, wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
`ifdef MDIO_EXT_REG_EN
    logic [15:0] clk_skew, rx_skew, tx_skew;
`endif

    logic st_oe, st_val;
    assign mdio_pin = st_oe ? st_val : (mdio_oe ? mdio_o : 1'b1);

    mdio_responder dut (
        .clock       (clock),
        .reset       (reset),
        .phy_addr    (phy_addr),
        .mdc         (mdc),
        .mdio_i      (mdio_pin),
        .mdio_o      (mdio_o),
        .mdio_oe     (mdio_oe),
        .link_speed  (link_speed),
        .link_duplex (link_duplex),
        .ctrl_reg    (ctrl_reg),
        .gbit_ctrl   (gbit_ctrl),
        .soft_reset  (soft_reset),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
`ifdef MDIO_EXT_REG_EN
        .clk_skew    (clk_skew),
        .rx_skew     (rx_skew),
        .tx_skew     (tx_skew),
`endif
        .wr_data     (wr_data)
    );

    always #5 clock = ~clock;

    int strobe_clks = 0, sreset_clks = 0, oe_clks = 0;
    always @(posedge clock) begin
        if (wr_strobe)  strobe_clks++;
        if (soft_reset) sreset_clks++;
        if (mdio_oe)    oe_clks++;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: the register map as plain arrays.
    logic [15:0] m_ctrl;
    logic [15:0] m_regs [0:31];
    logic [15:0] m_ext  [0:2];

    function automatic void model_reset();
        m_ctrl = 16'h1140;
        for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
        m_regs[9] = 16'h0300;
        for (int i = 0; i < 3; i++) m_ext[i] = 16'h0000;
    endfunction

    function automatic void model_write(input int a, input logic [15:0] d);
        if (a == 0) begin
            m_ctrl = d[15] ? 16'h1140 : {1'b0, d[14:0]};
        end else if (a >= 4 && a <= 15) begin
`ifdef MDIO_EXT_REG_EN
            if (a == 12 && m_regs[11][15]) begin
                if (m_regs[11][8:0] >= 9'h104 && m_regs[11][8:0] <= 9'h106)
                    m_ext[m_regs[11][8:0] - 9'h104] = d;
                return;
            end
`endif
            m_regs[a] = d;
        end
    endfunction

    function automatic logic [15:0] model_read(input int a);
        case (a)
            0:  return m_ctrl;
            1:  return 16'h796D;
            2:  return 16'h0022;
            3:  return 16'h1611;
            31: return 16'(link_speed) * 16'd32 + 16'(link_duplex) * 16'd8;
            default: begin
`ifdef MDIO_EXT_REG_EN
                if (a == 12 && !m_regs[11][15])
                    return (m_regs[11][8:0] >= 9'h104 && m_regs[11][8:0] <= 9'h106)
                           ? m_ext[m_regs[11][8:0] - 9'h104] : 16'h0000;
`endif
                return (a >= 4 && a <= 15) ? m_regs[a] : 16'h0000;
            end
        endcase
    endfunction

    task automatic mdc_bit(input logic b);
        st_oe = 1'b1;
        st_val = b;
        repeat (8) @(posedge clock);
        #1 mdc = 1'b1;
        repeat (8) @(posedge clock);
        #1 mdc = 1'b0;
    endtask

    // One station-manager frame; read frames collect TA/data from the pin.
    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input int abort_bit,
                         output logic [15:0] rd, output int oe_bits, output logic ta2);
        rd = '0;
        oe_bits = 0;
        ta2 = 1'b1;
        for (int i = 0; i < pre; i++) mdc_bit(1'b1);
        mdc_bit(1'b0);
        mdc_bit(1'b1);
        for (int i = 1; i >= 0; i--) mdc_bit(op[i]);
        for (int i = 4; i >= 0; i--) mdc_bit(pa[i]);
        for (int i = 4; i >= 0; i--) mdc_bit(ra[i]);
        if (op == 2'b10) begin
            st_oe = 1'b0;
            for (int i = 0; i < 18; i++) begin
                repeat (8) @(posedge clock);
                #1;
                if (mdio_oe) oe_bits++;
                if (i == 1) ta2 = mdio_pin;
                if (i >= 2) rd = {rd[14:0], mdio_pin};
                if (i == abort_bit) begin
                    reset = 1'b1;
                    #1;
                    chk("reset_oe_drop", {31'b0, mdio_oe}, 32'd0);
                    chk("reset_mdio_o", {31'b0, mdio_o}, 32'd1);
                    repeat (3) @(posedge clock);
                    #1 reset = 1'b0;
                    model_reset();
                    return;
                end
                mdc = 1'b1;
                repeat (8) @(posedge clock);
                #1;
                if (i == 17 && mdio_oe) oe_bits++;
                mdc = 1'b0;
            end
            st_oe = 1'b1;
            st_val = 1'b1;
        end else begin
            mdc_bit(1'b1);
            mdc_bit(1'b0);
            for (int i = 15; i >= 0; i--) mdc_bit(wd[i]);
        end
    endtask

    task automatic do_write(input int pre, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d);
        logic [15:0] rd;
        int ob;
        logic t2;
        frame(pre, 2'b01, pa, ra, d, -1, rd, ob, t2);
    endtask

    task automatic do_read(input logic [4:0] pa, input logic [4:0] ra,
                           output logic [15:0] rd, output int ob, output logic t2);
        frame(32, 2'b10, pa, ra, 16'h0, -1, rd, ob, t2);
    endtask

    initial begin
        logic [15:0] rd;
        int ob, s0, o0, r0;
        logic t2;
        logic [4:0] addrs [0:15];
        reset = 1'b1; phy_addr = 5'd1; mdc = 1'b0; st_oe = 1'b1; st_val = 1'b1;
        link_speed = 2'b00; link_duplex = 1'b0;
        model_reset();
        repeat (4) @(posedge clock);
        #1;
        chk("rst_oe", {31'b0, mdio_oe}, 0);
        chk("rst_o", {31'b0, mdio_o}, 1);
        chk("rst_ctrl", {16'b0, ctrl_reg}, 32'h1140);
        chk("rst_gbit", {16'b0, gbit_ctrl}, 32'h0300);
        chk("rst_strobes", {30'b0, wr_strobe, soft_reset}, 0);
        chk("rst_wr_addr", {27'b0, wr_addr}, 0);
        chk("rst_wr_data", {16'b0, wr_data}, 0);
        reset = 1'b0;
        repeat (4) @(posedge clock);

        s0 = strobe_clks; o0 = oe_clks;
        do_write(32, 5'd1, 5'd9, 16'h0200); model_write(9, 16'h0200);
        chk("w9_strobe", strobe_clks - s0, 1);
        chk("w9_addr", {27'b0, wr_addr}, 9);
        chk("w9_data", {16'b0, wr_data}, 32'h0200);
        chk("w9_gbit", {16'b0, gbit_ctrl}, 32'h0200);
        chk("w9_no_oe", oe_clks - o0, 0);

        link_speed = 2'b10; link_duplex = 1'b1;
        do_read(5'd1, 5'd31, rd, ob, t2);
        chk("r31_data", {16'b0, rd}, {16'b0, model_read(31)});
        chk("r31_const", {16'b0, rd}, 32'h0048);
        chk("r31_ta2", {31'b0, t2}, 0);
        chk("r31_oe_bits", ob, 17);

        s0 = strobe_clks; o0 = oe_clks;
        do_read(5'd3, 5'd2, rd, ob, t2);
        chk("skip_oe_bits", ob, 0);
        chk("skip_oe_clks", oe_clks - o0, 0);
        chk("skip_strobe", strobe_clks - s0, 0);
        do_read(5'd1, 5'd2, rd, ob, t2);
        chk("after_skip_id1", {16'b0, rd}, 32'h0022);

        s0 = strobe_clks;
        do_write(31, 5'd1, 5'd4, 16'h1234);
        chk("pre31_strobe", strobe_clks - s0, 0);
        do_read(5'd1, 5'd4, rd, ob, t2);
        chk("pre31_reg4", {16'b0, rd}, {16'b0, model_read(4)});
        s0 = strobe_clks;
        do_write(32, 5'd1, 5'd4, 16'h1234); model_write(4, 16'h1234);
        chk("pre32_strobe", strobe_clks - s0, 1);
        do_read(5'd1, 5'd4, rd, ob, t2);
        chk("pre32_reg4", {16'b0, rd}, 32'h1234);

        do_write(32, 5'd1, 5'd0, 16'h0000); model_write(0, 16'h0000);
        r0 = sreset_clks;
        do_write(32, 5'd1, 5'd0, 16'h8000); model_write(0, 16'h8000);
        chk("sreset_pulse", sreset_clks - r0, 1);
        do_read(5'd1, 5'd0, rd, ob, t2);
        chk("r0_after_sreset", {16'b0, rd}, 32'h1140);
        chk("ctrl_after_sreset", {16'b0, ctrl_reg}, 32'h1140);

        frame(32, 2'b10, 5'd1, 5'd3, 16'h0, 10, rd, ob, t2);
        chk("post_reset_gbit", {16'b0, gbit_ctrl}, 32'h0300);
        do_read(5'd1, 5'd3, rd, ob, t2);
        chk("post_reset_id2", {16'b0, rd}, 32'h1611);

`ifdef MDIO_EXT_REG_EN
        do_write(32, 5'd1, 5'd11, 16'h8104); model_write(11, 16'h8104);
        do_write(32, 5'd1, 5'd12, 16'h5270); model_write(12, 16'h5270);
        chk("ext_clk_skew", {16'b0, clk_skew}, 32'h5270);
        chk("ext_rx_skew", {16'b0, rx_skew}, 32'h0000);
        do_write(32, 5'd1, 5'd11, 16'h0104); model_write(11, 16'h0104);
        do_read(5'd1, 5'd12, rd, ob, t2);
        chk("ext_read12", {16'b0, rd}, 32'h5270);
`endif

        addrs = '{5'd0, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                  5'd13, 5'd14, 5'd15, 5'd16, 5'd20, 5'd1, 5'd31, 5'd2};
        for (int n = 0; n < 12; n++) begin
            logic [4:0]  wa, ra;
            logic [15:0] d;
            wa = addrs[$urandom_range(0, 12)];
            d  = 16'($urandom);
            s0 = strobe_clks;
            do_write(32 + $urandom_range(0, 3), 5'd1, wa, d);
            model_write(int'(wa), d);
            chk("rnd_w_strobe", strobe_clks - s0, 1);
            chk("rnd_w_addr", {27'b0, wr_addr}, {27'b0, wa});
            chk("rnd_w_data", {16'b0, wr_data}, {16'b0, d});
            link_speed = 2'($urandom); link_duplex = 1'($urandom);
            ra = addrs[$urandom_range(0, 15)];
            do_read(5'd1, ra, rd, ob, t2);
            chk("rnd_r_data", {16'b0, rd}, {16'b0, model_read(int'(ra))});
            chk("rnd_r_oe_bits", ob, 17);
            chk("rnd_ctrl", {16'b0, ctrl_reg}, {16'b0, m_ctrl});
            chk("rnd_gbit", {16'b0, gbit_ctrl}, {16'b0, m_regs[9]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
